// File: rtl/xdisp_scan.sv
// xdisp_scan: time-multiplexed N-digit hex 7-segment driver
// with guard time, leading-zero blanking and decimal points.
module xdisp_scan #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   data_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   lz_blank,
  input  logic                   en,
  output logic [6:0]             segments,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIGITS - 1);
  localparam logic [CW:0]   GUARD_W = (CW+1)'(GUARD);

  logic [4*NDIGITS-1:0] shadow_data;
  logic [NDIGITS-1:0]   shadow_dp;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;

  logic [3:0]           nib;
  logic [6:0]           hex;
  logic [NDIGITS-1:0]   zero_from;
  logic                 in_guard;
  logic                 blank;
  logic                 lit;
  logic [6:0]           seg_nxt;
  logic                 dp_nxt;
  logic [NDIGITS-1:0]   an_nxt;

  // Select the nibble for the digit currently being scanned
  always_comb begin
    nib = shadow_data[4*int'(idx) +: 4];
  end

  // Active-low hex glyph table
  always_comb begin
    hex = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
  end

  // zero_from[i]: nibbles i..NDIGITS-1 are all zero
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      acc          = acc & (shadow_data[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  // Decide what the pins show after the next edge
  always_comb begin
    in_guard = ({1'b0, cnt} + 1'b1) <= GUARD_W;
    blank    = lz_blank && (idx != '0)
             && zero_from[idx] && !shadow_dp[idx];
    lit      = en && !in_guard && !blank;
    seg_nxt  = 7'h7F;
    dp_nxt   = 1'b1;
    an_nxt   = '1;
    if (lit) begin
      seg_nxt = hex;
      dp_nxt  = ~shadow_dp[idx];
      an_nxt  = ~(NDIGITS'(1) << idx);
    end
  end

  // Shadow capture, slot/digit counters and registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      cnt         <= '0;
      idx         <= '0;
      segments    <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
    end else begin
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      segments <= seg_nxt;
      dp       <= dp_nxt;
      an       <= an_nxt;
    end
  end

endmodule
